// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits `count` pulses of high_len cycles high and low_len cycles low,
// followed by a one-cycle done strobe. The train can be aborted, and the reset is asynchronous.
module pulse_train_gen #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [CW-1:0] high_len,
    input  logic [CW-1:0] low_len,
    input  logic [CW-1:0] count,
    input  logic          abort,
    output logic          pulse,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] pulses_sent
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HIGH,
        S_LOW,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_high_len;
    logic [CW-1:0] r_low_len;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_phase;
    logic [CW-1:0] r_sent;
    logic          r_pulse;
    logic          r_busy;
    logic          r_done;

    logic          w_params_ok;
    assign w_params_ok = (high_len != '0) && (low_len != '0) && (count != '0);

    // The phase counter counts down to 1, so a full-scale length never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_high_len <= '0;
            r_low_len  <= '0;
            r_count    <= '0;
            r_phase    <= '0;
            r_sent     <= '0;
            r_pulse    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        r_sent <= '0;
                        if (w_params_ok) begin
                            r_high_len <= high_len;
                            r_low_len  <= low_len;
                            r_count    <= count;
                            r_phase    <= high_len;
                            r_pulse    <= 1'b1;
                            r_busy     <= 1'b1;
                            r_state    <= S_HIGH;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_HIGH: begin
                    if (abort) begin
                        r_pulse <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_phase == CW'(1)) begin
                        r_pulse <= 1'b0;
                        r_phase <= r_low_len;
                        r_sent  <= r_sent + CW'(1);
                        r_state <= S_LOW;
                    end else begin
                        r_phase <= r_phase - CW'(1);
                    end
                end
                S_LOW: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_phase == CW'(1)) begin
                        if (r_sent < r_count) begin
                            r_pulse <= 1'b1;
                            r_phase <= r_high_len;
                            r_state <= S_HIGH;
                        end else begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_phase <= r_phase - CW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_pulse <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pulse       = r_pulse;
    assign busy        = r_busy;
    assign done        = r_done;
    assign pulses_sent = r_sent;

endmodule
